// File: rtl/uart_rx_oversampler.sv
// ---------------------------------------------------------------------------
// uart_rx_oversampler
//
// Receive front end for the UART RX path. The block synchronises the raw
// serial line, looks for the falling edge of a start bit, and then runs an
// oversampling edge counter that frames every bit period. The counter drives
// a bit tick for the controller's bit counter and a 3-sample majority vote
// (with a disagreement flag) for the parity/start/stop checkers and the
// deserializer.
//
// Ports
//   clk                 system clock, rising edge
//   rst                 asynchronous active-high reset
//   RX_IN               raw serial line (idle high, asynchronous to clk)
//   Prescale            oversampling ratio, latched when a start is detected
//   sampler_en          run permission from the RX controller
//   start_bit_detector  1-cycle pulse in the start-detection cycle
//   BIT_TICK            1-cycle pulse on the last oversample edge of a bit
//   sampled_bit         majority-voted bit value (held between updates)
//   sample_valid        1-cycle pulse when sampled_bit/noise_flag update
//   noise_flag          the three samples of the last voted bit disagreed
// ---------------------------------------------------------------------------
module uart_rx_oversampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  sampler_en,
  output logic                  start_bit_detector,
  output logic                  BIT_TICK,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  noise_flag
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam logic [PRESCALE_W-1:0] ONE   = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(4);
  localparam logic [PRESCALE_W-1:0] P_RST = PRESCALE_W'(8);

  // -------------------------------------------------------------------------
  // Line synchroniser. rx_s is the metastability-safe copy of the line and
  // rx_d is its one-cycle history used for edge detection. Everything resets
  // to the idle (high) level so reset release never looks like a start.
  // -------------------------------------------------------------------------
  logic sync_q, rx_s_q, rx_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_d_q <= 1'b1;
    end else begin
      sync_q <= RX_IN;
      rx_s_q <= sync_q;
      rx_d_q <= rx_s_q;
    end
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e                  state_q;
  logic [PRESCALE_W-1:0]   edge_cnt_q;
  logic [PRESCALE_W-1:0]   edge_cnt_d;
  logic [PRESCALE_W-1:0]   p_lat_q;
  logic                    s0_q, s1_q;
  logic                    sampled_bit_q;
  logic                    sample_valid_q;
  logic                    noise_flag_q;

  // -------------------------------------------------------------------------
  // Decode of the edge counter against the latched ratio
  // -------------------------------------------------------------------------
  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] last_edge;
  logic [PRESCALE_W-1:0] p_sel;
  logic                  active;
  logic                  fall_seen;
  logic                  at_last;
  logic                  at_s0, at_s1, at_s2;
  logic                  s2;
  logic                  vote_bit;
  logic                  vote_noise;

  assign mid       = p_lat_q >> 1;
  assign last_edge = p_lat_q - ONE;
  // Ratios below 4 cannot fit three samples plus a vote into one bit period.
  assign p_sel     = (Prescale < P_MIN) ? P_MIN : Prescale;

  assign active    = (state_q != HUNT);
  assign fall_seen = rx_d_q & ~rx_s_q;
  assign at_last   = (edge_cnt_q == last_edge);
  assign at_s0     = (edge_cnt_q == (mid - ONE));
  assign at_s1     = (edge_cnt_q == mid);
  assign at_s2     = (edge_cnt_q == (mid + ONE));

  // Third sample is taken straight from the line in the mid+1 cycle and the
  // vote is registered on the same clock edge, so the result is visible in
  // the edge mid+2 cycle (edge 0 of the next bit for the minimum ratio of 4).
  assign s2         = rx_s_q;
  assign vote_bit   = (s0_q & s1_q) | (s0_q & s2) | (s1_q & s2);
  assign vote_noise = (s0_q | s1_q | s2) & ~(s0_q & s1_q & s2);

  assign edge_cnt_d = at_last ? '0 : (edge_cnt_q + ONE);

  // -------------------------------------------------------------------------
  // Main FSM: start hunt, one-cycle arm window, bit-period counting, voting
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= HUNT;
      edge_cnt_q     <= '0;
      p_lat_q        <= P_RST;
      s0_q           <= 1'b1;
      s1_q           <= 1'b1;
      sampled_bit_q  <= 1'b1;
      sample_valid_q <= 1'b0;
      noise_flag_q   <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;

      // The first sample can land in the arm cycle for small ratios, so the
      // sample capture runs in every non-hunting state.
      if (active && at_s0) s0_q <= rx_s_q;
      if (active && at_s1) s1_q <= rx_s_q;

      case (state_q)
        HUNT: begin
          edge_cnt_q <= '0;
          if (fall_seen) begin
            // Detection cycle is edge 0 of the start bit.
            p_lat_q    <= p_sel;
            edge_cnt_q <= ONE;
            state_q    <= ARMED;
          end
        end

        ARMED: begin
          // Controller answers a start exactly one cycle after the pulse;
          // no answer means the start was rejected.
          if (sampler_en) begin
            edge_cnt_q <= edge_cnt_d;
            state_q    <= RUN;
          end else begin
            edge_cnt_q <= '0;
            state_q    <= HUNT;
          end
        end

        RUN: begin
          if (!sampler_en) begin
            // Abort wins over wrap and drops any half-collected vote.
            edge_cnt_q <= '0;
            state_q    <= HUNT;
          end else begin
            edge_cnt_q <= edge_cnt_d;
            if (at_s2) begin
              sampled_bit_q  <= vote_bit;
              noise_flag_q   <= vote_noise;
              sample_valid_q <= 1'b1;
            end
          end
        end

        default: begin
          edge_cnt_q <= '0;
          state_q    <= HUNT;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. Pulses are decoded from registered state only, so there is no
  // path from RX_IN to any output.
  // -------------------------------------------------------------------------
  assign start_bit_detector = (state_q == HUNT) & fall_seen;
  assign BIT_TICK           = active & at_last;
  assign sampled_bit        = sampled_bit_q;
  assign sample_valid       = sample_valid_q;
  assign noise_flag         = noise_flag_q;

endmodule

// File: tb/tb_uart_rx_oversampler.sv
module tb_uart_rx_oversampler;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       sampler_en;
  logic       start_bit_detector, BIT_TICK, sampled_bit, sample_valid, noise_flag;

  uart_rx_oversampler #(.PRESCALE_W(6)) dut (
    .clk                (clk),
    .rst                (rst),
    .RX_IN              (RX_IN),
    .Prescale           (Prescale),
    .sampler_en         (sampler_en),
    .start_bit_detector (start_bit_detector),
    .BIT_TICK           (BIT_TICK),
    .sampled_bit        (sampled_bit),
    .sample_valid       (sample_valid),
    .noise_flag         (noise_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model. The line as seen by the block is a delayed copy of
  // RX_IN; a frame is "active" from a detected fall until sampler_en is seen
  // low. Inside a frame, time t since detection gives the edge t mod P; the
  // vote uses the last three line values once edge mid+1 is reached.
  // -------------------------------------------------------------------------
  logic hq[$] = '{1'b1, 1'b1, 1'b1, 1'b1};
  bit   act   = 0;
  int   t     = 0;
  int   P     = 8;
  logic m_bit = 1'b1, m_valid = 1'b0, m_noise = 1'b0;

  // event logs read by the stimulus for literal checks
  int   m_nv = 0, m_ticks = 0, m_starts = 0, m_det_cyc = 0, m_ftick_cyc = 0;
  bit   m_tick_seen = 0;
  logic m_vote [0:1023];
  logic m_vnz  [0:1023];

  always @(negedge clk) begin : model
    logic h2, h3, h4, xs, xt, xb, xv, xn, maj;
    int   e, mid;
    h2 = hq[hq.size()-2];
    h3 = hq[hq.size()-3];
    h4 = hq[hq.size()-4];
    if (rst) begin
      xs = 0; xt = 0; xb = 1; xv = 0; xn = 0;
    end else begin
      xb = m_bit; xv = m_valid; xn = m_noise;
      if (!act) begin xs = h3 & ~h2; xt = 0; end
      else      begin xs = 0; xt = ((t % P) == P - 1); end
    end
    chk("start_bit_detector", start_bit_detector, xs);
    chk("BIT_TICK",           BIT_TICK,           xt);
    chk("sampled_bit",        sampled_bit,        xb);
    chk("sample_valid",       sample_valid,       xv);
    chk("noise_flag",         noise_flag,         xn);

    if (rst) begin
      act = 0; t = 0; m_bit = 1; m_valid = 0; m_noise = 0;
    end else begin
      m_valid = 0;
      if (xt) begin
        m_ticks++;
        if (!m_tick_seen) begin m_tick_seen = 1; m_ftick_cyc = cyc; end
      end
      if (!act) begin
        if (xs) begin
          act = 1; t = 1;
          P = (Prescale < 4) ? 4 : int'(Prescale);
          m_starts++; m_det_cyc = cyc; m_tick_seen = 0;
        end
      end else if (!sampler_en) begin
        act = 0; t = 0;
      end else begin
        e = t % P; mid = P / 2;
        if (e == mid + 1) begin
          maj = (h4 + h3 + h2) >= 2;
          m_bit = maj;
          m_noise = !((h4 == h3) && (h3 == h2));
          m_valid = 1;
          if (m_nv < 1024) begin m_vote[m_nv] = m_bit; m_vnz[m_nv] = m_noise; end
          m_nv++;
        end
        t++;
      end
    end
    hq.push_back(rst ? 1'b1 : RX_IN);
    if (hq.size() > 8) void'(hq.pop_front());
    cyc++;
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  int fall_cyc, b_nv, b_ticks, b_starts;

  // Drives one frame: start, 8 data LSB first, stop. Frame bit b occupies
  // drive cycles [b*per, (b+1)*per); bits at or beyond nbits are idle high.
  // sampler_en is high for cycles [3, 3+en_len) (-1: whole frame).
  task automatic run_frame(input int pres, input logic [7:0] data, input int nbits,
                           input int en_len, input int glitch_k,
                           input int pchg_k, input int pchg_val);
    int per, len;
    logic [9:0] fr;
    logic b;
    per = (pres < 4) ? 4 : pres;
    len = (en_len < 0) ? 10 * per - 1 : en_len;
    fr  = {1'b1, data, 1'b0};
    b_nv = m_nv; b_ticks = m_ticks; b_starts = m_starts;
    Prescale = 6'(pres);
    for (int k = 0; k < 10 * per + 4; k++) begin
      b = ((k / per) < nbits && (k / per) < 10) ? fr[k / per] : 1'b1;
      if (k == glitch_k) b = ~b;
      RX_IN      = b;
      sampler_en = (k >= 3 && k < 3 + len);
      if (k == pchg_k) Prescale = 6'(pchg_val);
      if (k == 0) fall_cyc = cyc;
      @(posedge clk); #1;
    end
    RX_IN = 1'b1; sampler_en = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  function automatic int votes(input int n);
    int v = 0;
    for (int i = 0; i < n; i++) if (m_vote[b_nv + i]) v |= (1 << i);
    return v;
  endfunction

  function automatic int noises(input int n);
    int v = 0;
    for (int i = 0; i < n; i++) if (m_vnz[b_nv + i]) v |= (1 << i);
    return v;
  endfunction

  initial begin
    rst = 1'b1; RX_IN = 1'b0; sampler_en = 1'b0; Prescale = 6'd8;
    repeat (4) @(posedge clk);
    #1;
    // reset with the line held low: idle outputs, no start
    chk("rst_start",  start_bit_detector, 0);
    chk("rst_tick",   BIT_TICK,           0);
    chk("rst_bit",    sampled_bit,        1);
    chk("rst_valid",  sample_valid,       0);
    chk("rst_noise",  noise_flag,         0);
    RX_IN = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    b_starts = m_starts;
    repeat (8) @(posedge clk);
    #1;
    chk("idle_no_start", m_starts - b_starts, 0);

    // P=8, 0x55
    run_frame(8, 8'h55, 10, -1, -1, -1, 0);
    chk("p8_starts",     m_starts - b_starts, 1);
    chk("p8_det_lat",    m_det_cyc - fall_cyc, 2);
    chk("p8_ticks",      m_ticks - b_ticks, 10);
    chk("p8_first_tick", m_ftick_cyc - m_det_cyc, 7);
    chk("p8_nvotes",     m_nv - b_nv, 10);
    chk("p8_votes",      votes(10), 'h2AA);
    chk("p8_noise",      noises(10), 0);

    // P=16, 0x0F, one-cycle glitch on the mid sample of data bit 3
    run_frame(16, 8'h0F, 10, -1, 4 * 16 + 8, -1, 0);
    chk("p16_ticks",      m_ticks - b_ticks, 10);
    chk("p16_first_tick", m_ftick_cyc - m_det_cyc, 15);
    chk("p16_votes",      votes(10), 'h21E);
    chk("p16_noise",      noises(10), 'h010);

    // start rejected by the controller, then a normal frame
    run_frame(8, 8'h00, 1, 0, -1, -1, 0);
    chk("rej_starts", m_starts - b_starts, 1);
    chk("rej_ticks",  m_ticks - b_ticks, 0);
    chk("rej_votes",  m_nv - b_nv, 0);
    run_frame(8, 8'hC4, 10, -1, -1, -1, 0);
    chk("after_rej_starts", m_starts - b_starts, 1);
    chk("after_rej_votes",  votes(10), 'h388);

    // P=32, Prescale changed mid-frame, sampler_en dropped at edge 12 of bit 4
    run_frame(32, 8'h33, 5, 139, -1, 50, 16);
    chk("p32_first_tick", m_ftick_cyc - m_det_cyc, 31);
    chk("p32_ticks",      m_ticks - b_ticks, 4);
    chk("p32_nvotes",     m_nv - b_nv, 4);
    chk("p32_votes",      votes(4), 'h6);
    run_frame(16, 8'h3C, 10, -1, -1, -1, 0);
    chk("p16b_first_tick", m_ftick_cyc - m_det_cyc, 15);
    chk("p16b_votes",      votes(10), 'h278);

    // Prescale=2 is forced to 4
    run_frame(2, 8'hA5, 10, -1, -1, -1, 0);
    chk("p4_ticks",      m_ticks - b_ticks, 10);
    chk("p4_first_tick", m_ftick_cyc - m_det_cyc, 3);
    chk("p4_nvotes",     m_nv - b_nv, 10);
    chk("p4_votes",      votes(10), 'h34A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
